// File: rtl/serial_digit_checker.sv
// Serial MSB-first symbol assembler with an in-range check (value < LIMIT) done bit by bit.
// Optional saturating error counter built only when SERIAL_DIGIT_ERRCNT_EN is defined.
module serial_digit_checker #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 10,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_start,
  output logic             busy,
  output logic             digit_valid,
  output logic             digit_ok,
  output logic [WIDTH-1:0] digit_value,
  output logic             abort_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int                IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]  LIM   = WIDTH'(LIMIT);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_t;

  state_t           state, state_n;
  cmp_t             cmp, cmp_n, cmp_b;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] shreg, shreg_n, value_n;
  logic             valid_n, ok_n, abort_n;

  // Magnitude compare one bit at a time: the first differing bit decides, then it sticks.
  function automatic cmp_t cmp_step(input cmp_t cur, input logic b, input logic lb);
    cmp_t res;
    res = cur;
    if (cur == CMP_EQ && b != lb) res = b ? CMP_GT : CMP_LT;
    return res;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cmp         <= CMP_EQ;
      shreg       <= '0;
      digit_valid <= 1'b0;
      digit_ok    <= 1'b0;
      digit_value <= '0;
      abort_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cmp         <= cmp_n;
      shreg       <= shreg_n;
      digit_valid <= valid_n;
      digit_ok    <= ok_n;
      digit_value <= value_n;
      abort_pulse <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cmp_n   = cmp;
    cmp_b   = CMP_EQ;
    shreg_n = shreg;
    valid_n = 1'b0;
    ok_n    = digit_ok;
    value_n = digit_value;
    abort_n = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        // A new MSB always restarts; if a symbol was in flight it is discarded.
        abort_n = (state == SHIFT);
        shreg_n = {{(WIDTH-1){1'b0}}, bit_in};
        cmp_n   = cmp_step(CMP_EQ, bit_in, LIM[WIDTH-1]);
        idx_n   = IDX_W'(1);
        state_n = SHIFT;
      end else if (state == SHIFT) begin
        shreg_n = {shreg[WIDTH-2:0], bit_in};
        cmp_b   = cmp_step(cmp, bit_in, LIM[LAST - idx]);
        if (idx == LAST) begin
          state_n = IDLE;
          idx_n   = '0;
          cmp_n   = CMP_EQ;
          valid_n = 1'b1;
          ok_n    = (cmp_b == CMP_LT);
          value_n = shreg_n;
        end else begin
          cmp_n = cmp_b;
          idx_n = idx + IDX_W'(1);
        end
      end
    end
  end

  assign busy = (state == SHIFT);

`ifdef SERIAL_DIGIT_ERRCNT_EN
  logic err_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Counter moves together with the registered pulse it accounts for.
  assign err_evt = abort_n | (valid_n & ~ok_n);

  always_ff @(posedge clock) begin
    if (reset)        err_count <= '0;
    else if (err_evt) err_count <= sat_inc(err_count);
  end
`else
  assign err_count = '0;
`endif

endmodule
